// File: rtl/sub_bytes_seq.sv
`default_nettype none
// ============================================================================
// Module   : aes_sbox / sub_bytes_seq
// Purpose  : Iterative AES SubBytes stage. BYTES_PER_CYCLE S-box copies are
//            time-multiplexed over the 128-bit state.
// Revision : 1.0
// ============================================================================

module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  logic [7:0] w_inv;

  always_comb begin
    w_inv  = gf_inv(i_byte);
    o_byte = w_inv
           ^ {w_inv[6:0], w_inv[7]}
           ^ {w_inv[5:0], w_inv[7:6]}
           ^ {w_inv[4:0], w_inv[7:5]}
           ^ {w_inv[3:0], w_inv[7:4]}
           ^ 8'h63;
  end

endmodule

module sub_bytes_seq #(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int N_CHUNKS = 16 / BYTES_PER_CYCLE;
  localparam int CNT_W    = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_CHUNKS - 1);

  if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
        BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bytes_per_cycle
    $error("sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [127:0]       work_q,  work_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;

  logic [3:0]         w_idx    [BYTES_PER_CYCLE];
  logic [7:0]         w_sb_in  [BYTES_PER_CYCLE];
  logic [7:0]         w_sb_out [BYTES_PER_CYCLE];

  // Byte i sits at bits [127-8i -: 8]; its low bit offset is {~i, 3'b000}.
  for (genvar b = 0; b < BYTES_PER_CYCLE; b++) begin : g_sbox
    assign w_idx[b]   = 4'(cnt_q) * 4'(BYTES_PER_CYCLE) + 4'(b);
    assign w_sb_in[b] = work_q[{~w_idx[b], 3'b000} +: 8];
    aes_sbox u_sbox (
      .i_byte (w_sb_in[b]),
      .o_byte (w_sb_out[b])
    );
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          work_d  = in_state;
          cnt_d   = '0;
          state_d = ST_SUB;
        end
      end
      ST_SUB: begin
        for (int b = 0; b < BYTES_PER_CYCLE; b++) begin
          work_d[{~w_idx[b], 3'b000} +: 8] = w_sb_out[b];
        end
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_SUB) || (state_q == ST_DONE);
  assign out_state = work_q;

endmodule

`default_nettype wire

// File: tb/tb_sub_bytes_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_sub_bytes_seq
// Purpose  : Self-checking bench for sub_bytes_seq against a table-based model.
// Revision : 1.0
// ============================================================================

module tb_sub_bytes_seq;

  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  logic               sw_valid;
  logic [127:0]       sw_state;
  logic [3:0]         sw_ir;
  logic [3:0]         sw_ov;
  logic [3:0]         sw_busy;
  logic [3:0][127:0]  sw_out;
  int                 sw_lat [4] = '{16, 8, 2, 1};

  int checks = 0;
  int errors = 0;

  logic [7:0] sbox_tbl [256];

  always #5 clk = ~clk;

  sub_bytes_seq #(.BYTES_PER_CYCLE(4)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  for (genvar i = 0; i < 4; i++) begin : g_sweep
    localparam int BPC = (i == 0) ? 1 : (i == 1) ? 2 : (i == 2) ? 8 : 16;
    sub_bytes_seq #(.BYTES_PER_CYCLE(BPC)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (sw_valid),
      .in_ready  (sw_ir[i]),
      .in_state  (sw_state),
      .out_valid (sw_ov[i]),
      .out_ready (1'b1),
      .out_state (sw_out[i]),
      .busy      (sw_busy[i])
    );
  end

  // S-box from exp/log tables over generator 3, then the bitwise affine map.
  task automatic build_sbox();
    logic [7:0] ex [256];
    int         lg [256];
    logic [7:0] x, inv, s, c;
    c = 8'h63;
    x = 8'h01;
    for (int i = 0; i < 255; i++) begin
      ex[i] = x;
      lg[x] = i;
      x = x ^ ({x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00));
    end
    for (int v = 0; v < 256; v++) begin
      inv = (v == 0) ? 8'h00 : ex[(255 - lg[v]) % 255];
      for (int b = 0; b < 8; b++)
        s[b] = inv[b] ^ inv[(b + 4) % 8] ^ inv[(b + 5) % 8] ^ inv[(b + 6) % 8] ^ inv[(b + 7) % 8] ^ c[b];
      sbox_tbl[v] = s;
    end
  endtask

  function automatic logic [127:0] model_sub(input logic [127:0] st);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = sbox_tbl[st[127 - 8*i -: 8]];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One transaction on the main DUT; out_ready is held low for 'hold' DONE cycles.
  task automatic txn(input logic [127:0] st, input int hold, output logic [127:0] got);
    logic [127:0] exp_s;
    exp_s = model_sub(st);
    chk("idle_in_ready", in_ready, 1'b1);
    in_valid  = 1'b1;
    in_state  = st;
    out_ready = (hold == 0);
    step();
    in_valid = 1'b0;
    in_state = rand128();
    chk("accept_busy", busy, 1'b1);
    chk("accept_in_ready", in_ready, 1'b0);
    for (int j = 1; j <= LAT; j++) begin
      step();
      chk("lat_out_valid", out_valid, (j == LAT));
    end
    got = out_state;
    chk("result", out_state, exp_s);
    for (int h = 0; h < hold; h++) begin
      chk("hold_out_valid", out_valid, 1'b1);
      chk("hold_out_state", out_state, exp_s);
      chk("hold_in_ready", in_ready, 1'b0);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("post_out_valid", out_valid, 1'b0);
    chk("post_in_ready", in_ready, 1'b1);
    chk("post_busy", busy, 1'b0);
  endtask

  task automatic sweep(input logic [127:0] st, input logic [127:0] exp_s);
    for (int i = 0; i < 4; i++) chk("sweep_in_ready", sw_ir[i], 1'b1);
    sw_valid = 1'b1;
    sw_state = st;
    step();
    sw_valid = 1'b0;
    sw_state = rand128();
    for (int i = 0; i < 4; i++) chk("sweep_busy", sw_busy[i], 1'b1);
    for (int j = 1; j <= 18; j++) begin
      step();
      for (int i = 0; i < 4; i++) begin
        chk("sweep_out_valid", sw_ov[i], (j == sw_lat[i]));
        if (j == sw_lat[i]) chk("sweep_out_state", sw_out[i], exp_s);
      end
    end
  endtask

  initial begin
    logic [127:0] got, a, b;
    rst = 1'b1; in_valid = 1'b0; in_state = '0; out_ready = 1'b1;
    sw_valid = 1'b0; sw_state = '0;
    build_sbox();
    step(); step();
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_state", out_state, 128'h0);
    chk("rst_in_ready",  in_ready,  1'b1);
    chk("rst_busy",      busy,      1'b0);

    txn(128'h193de3bea0f4e22b9ac68d2ae9f84808, 0, got);
    chk("fips_vector", got, 128'hd42711aee0bf98f1b8b45de51e415230);
    txn(128'h00112233445566778899aabbccddeeff, 0, got);
    chk("byte_order", got, 128'h638293c31bfc33f5c4eeacea4bc12816);
    txn(128'h0, 10, got);
    chk("backpressure", got, {16{8'h63}});

    for (int t = 0; t < 6; t++) txn(rand128(), int'($urandom_range(0, 3)), got);

    // Second request raised while busy must wait for IDLE.
    a = rand128(); b = rand128();
    in_valid = 1'b1; in_state = a; out_ready = 1'b1;
    step();
    in_state = b;
    for (int j = 1; j <= LAT; j++) begin
      step();
      chk("rej_out_valid", out_valid, (j == LAT));
    end
    chk("rej_first_result", out_state, model_sub(a));
    step();
    chk("rej_idle_in_ready", in_ready, 1'b1);
    chk("rej_idle_state", out_state, model_sub(a));
    step();
    in_valid = 1'b0;
    chk("rej_second_busy", busy, 1'b1);
    for (int j = 1; j <= LAT; j++) step();
    chk("rej_second_valid", out_valid, 1'b1);
    chk("rej_second_result", out_state, model_sub(b));
    step();

    // Reset in the middle of SUB discards the transaction.
    in_valid = 1'b1; in_state = rand128();
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_out_state", out_state, 128'h0);
    chk("abort_in_ready",  in_ready,  1'b1);
    chk("abort_busy",      busy,      1'b0);
    for (int j = 0; j < 6; j++) begin
      step();
      chk("abort_no_pulse", out_valid, 1'b0);
    end

    sweep(128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'hd42711aee0bf98f1b8b45de51e415230);
    sweep(128'h00112233445566778899aabbccddeeff, 128'h638293c31bfc33f5c4eeacea4bc12816);
    a = rand128();
    sweep(a, model_sub(a));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
